mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Parametrised multi-channel successor to the North Bridge single-port memory read/write enable logic.
- Accepts read/write requests from NUM_CH masters and arbitrates them round-robin onto one memory port.
- Respects the memory busy flag, issues single-cycle strobes, waits for acknowledge, and returns read data, completion and timeout-error status per channel.

Parameters:
- NUM_CH, 2, number of requesting channels (2..8).
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- TIMEOUT, 15, maximum WAIT cycles before an access is aborted with an error (1..255).

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous active-low reset, sampled on posedge clk.
- ch_req  in  NUM_CH  per-channel request; hold high until ch_grant.
- ch_we  in  NUM_CH  per-channel direction: 1 = write, 0 = read.
- ch_addr  in  NUM_CH*ADDR_W  packed addresses; channel i at bits [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*DATA_W  packed write data, same packing.
- ch_grant  out  NUM_CH  one-hot, one-cycle pulse when the channel's request is accepted.
- ch_done  out  NUM_CH  one-hot, one-cycle pulse on completion.
- ch_err  out  NUM_CH  one-cycle pulse coincident with ch_done on timeout.
- ch_rdata  out  DATA_W  read data of the last completed read.
- mem_busy  in  1  memory busy; new access is not started while high.
- mem_rd  out  1  read strobe, one cycle.
- mem_wr  out  1  write strobe, one cycle.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mem_ack  in  1  access complete.

Behaviour:
- All outputs registered.
- Reset (rst=0 at a posedge):
  - All outputs 0; state IDLE; timer 0; last_grant = NUM_CH-1, so ch0 has first priority.
  - Takes effect mid-operation: strobes drop at that edge, no ch_done/ch_err is issued for the aborted access, and the round-robin pointer resets.
- States:
  - IDLE:
    - Leaves only when mem_busy=0 and any ch_req=1.
    - Winner = first requesting channel searching from (last_grant+1) mod NUM_CH upward, wrapping.
    - On that edge: ch_grant[winner]=1; mem_rd=!ch_we[w]; mem_wr=ch_we[w]; mem_addr and mem_wdata latched from the winner's slice; last_grant=w; go to ISSUE.
    - With mem_busy=1: no grant, stay in IDLE.
  - ISSUE (exactly one cycle, strobe visible):
    - Next edge: ch_grant, mem_rd and mem_wr return to 0; timer=0; go to WAIT.
    - mem_addr and mem_wdata hold until the next grant.
  - WAIT:
    - mem_ack=1: if the access is a read, ch_rdata=mem_rdata (writes leave ch_rdata unchanged); ch_done[w]=1; go to DONE.
    - Otherwise, if timer==TIMEOUT-1: ch_done[w]=1, ch_err[w]=1; go to DONE.
    - Otherwise timer+1.
    - Ack on the expiry cycle wins: no error is flagged.
  - DONE (one cycle): clear ch_done and ch_err; go to IDLE.
- Input sampling rules:
  - mem_ack is ignored outside WAIT.
  - mem_busy is sampled only in IDLE.
  - ch_req and the channel inputs are ignored after grant (already latched).
  - A request dropped before grant is withdrawn.
- Latency and timing:
  - Minimum request-to-done latency: grant edge + 1 ISSUE + 1 WAIT = ch_done 2 cycles after ch_grant.
  - Back-to-back grant spacing: at least 4 cycles.
- Timer width: ceil(log2(TIMEOUT+1)) bits; the timer never wraps.

Test Plan:
- Reset: rst=0 for 3 cycles with ch_req=2'b11, mem_busy=0 -> every output 0 and no grant; after release, first grant is ch0.
- Single read: ch0 read of addr 0x1234; mem_ack with mem_rdata=0xA5 on the 3rd WAIT cycle.
  - Response: ch_grant=01 for 1 cycle; mem_rd=1 for exactly 1 cycle with mem_addr=0x1234.
  - Response: ch_done=01 one cycle after the ack edge; ch_rdata=0xA5; ch_err=0.
- Round-robin: both channels hold writes (ch0 wdata 0x11, ch1 wdata 0x22) with ack after 1 cycle -> grants alternate ch0, ch1, ch0, ch1; mem_wdata alternates 0x11/0x22; mem_rd never asserts.
- Busy stall: mem_busy=1 for 5 cycles while ch1 requests -> no grant during busy; ch_grant=10 on the first edge busy is sampled 0.
- Timeout (TIMEOUT=4):
  - No ack -> ch_done and ch_err pulse together after exactly 4 WAIT cycles; the following request completes normally.
  - Repeat with ack on the 4th WAIT cycle -> ch_done=1 and ch_err=0.
- Reset mid-access: rst=0 during WAIT of a ch1 access -> mem_rd, mem_wr and ch_done stay 0; with both channels requesting after release, the grant goes to ch0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Round-robin arbiter that funnels read/write requests from NUM_CH masters onto
// a single memory port. A granted access issues a one-cycle strobe, waits for
// mem_ack (or gives up after TIMEOUT wait cycles), then reports completion,
// timeout error and read data back to the owning channel.
//
// Ports:
//   clk        - single clock, all logic on posedge
//   rst        - synchronous active-low reset
//   ch_req     - per-channel request, held high until ch_grant
//   ch_we      - per-channel direction, 1 = write, 0 = read
//   ch_addr    - packed addresses, channel i at [i*ADDR_W +: ADDR_W]
//   ch_wdata   - packed write data, channel i at [i*DATA_W +: DATA_W]
//   ch_grant   - one-hot, one-cycle pulse when a request is accepted
//   ch_done    - one-hot, one-cycle pulse when the access completes
//   ch_err     - one-cycle pulse with ch_done when the access timed out
//   ch_rdata   - read data of the last completed read
//   mem_busy   - memory busy, blocks the start of a new access
//   mem_rd     - one-cycle read strobe
//   mem_wr     - one-cycle write strobe
//   mem_addr   - access address, held until the next grant
//   mem_wdata  - write data, held until the next grant
//   mem_rdata  - read data, valid with mem_ack
//   mem_ack    - access complete
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int NUM_CH  = 2,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          ch_req,
   input  logic [NUM_CH-1:0]          ch_we,
   input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
   input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
   output logic [NUM_CH-1:0]          ch_grant,
   output logic [NUM_CH-1:0]          ch_done,
   output logic [NUM_CH-1:0]          ch_err,
   output logic [DATA_W-1:0]          ch_rdata,
   input  logic                       mem_busy,
   output logic                       mem_rd,
   output logic                       mem_wr,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   input  logic [DATA_W-1:0]          mem_rdata,
   input  logic                       mem_ack
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   localparam logic [NUM_CH-1:0] CH_ONE    = NUM_CH'(1);
   localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
   localparam logic [TMR_W-1:0]  TMR_LIMIT = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t              state_q,      state_d;
   logic [TMR_W-1:0]    timer_q,      timer_d;
   logic [CH_W-1:0]     last_grant_q, last_grant_d;
   logic                we_q,         we_d;
   logic [NUM_CH-1:0]   ch_grant_q,   ch_grant_d;
   logic [NUM_CH-1:0]   ch_done_q,    ch_done_d;
   logic [NUM_CH-1:0]   ch_err_q,     ch_err_d;
   logic [DATA_W-1:0]   ch_rdata_q,   ch_rdata_d;
   logic                mem_rd_q,     mem_rd_d;
   logic                mem_wr_q,     mem_wr_d;
   logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;

   // Per-channel views of the packed address/data buses.
   logic [ADDR_W-1:0]   addr_arr  [NUM_CH];
   logic [DATA_W-1:0]   wdata_arr [NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
      assign addr_arr[g]  = ch_addr[g*ADDR_W +: ADDR_W];
      assign wdata_arr[g] = ch_wdata[g*DATA_W +: DATA_W];
   end

   // Round-robin search: first requester strictly above last_grant, else the
   // first requester at or below it (the wrap-around half).
   logic                found;
   logic [CH_W-1:0]     winner;
   logic                start;
   logic                timer_expired;

   always_comb begin
      // NOTE: every variable written in a combinational block gets a default
      // first; a path that leaves one unassigned would infer a latch.
      found  = 1'b0;
      winner = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found && ch_req[i] && (i > int'(last_grant_q))) begin
            found  = 1'b1;
            winner = CH_W'(i);
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found && ch_req[i] && (i <= int'(last_grant_q))) begin
            found  = 1'b1;
            winner = CH_W'(i);
         end
      end
   end

   assign start         = (state_q == ST_IDLE) && !mem_busy && found;
   assign timer_expired = (timer_q == TMR_LIMIT);

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (!rst) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         last_grant_q <= CH_LAST;
         we_q         <= 1'b0;
         ch_grant_q   <= '0;
         ch_done_q    <= '0;
         ch_err_q     <= '0;
         ch_rdata_q   <= '0;
         mem_rd_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         ch_grant_q   <= ch_grant_d;
         ch_done_q    <= ch_done_d;
         ch_err_q     <= ch_err_d;
         ch_rdata_q   <= ch_rdata_d;
         mem_rd_q     <= mem_rd_d;
         mem_wr_q     <= mem_wr_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (mem_ack || timer_expired) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output and datapath logic. Pulses default to 0; held values default to
   // their current contents.
   always_comb begin
      ch_grant_d   = '0;
      ch_done_d    = '0;
      ch_err_d     = '0;
      mem_rd_d     = 1'b0;
      mem_wr_d     = 1'b0;
      timer_d      = timer_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      ch_rdata_d   = ch_rdata_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               ch_grant_d   = CH_ONE << winner;
               we_d         = ch_we[winner];
               mem_rd_d     = !ch_we[winner];
               mem_wr_d     = ch_we[winner];
               mem_addr_d   = addr_arr[winner];
               mem_wdata_d  = wdata_arr[winner];
               last_grant_d = winner;
            end
         end
         ST_ISSUE: begin
            timer_d = '0;
         end
         ST_WAIT: begin
            // An ack on the expiry cycle takes priority over the timeout.
            if (mem_ack) begin
               if (!we_q) ch_rdata_d = mem_rdata;
               ch_done_d = CH_ONE << last_grant_q;
            end else if (timer_expired) begin
               ch_done_d = CH_ONE << last_grant_q;
               ch_err_d  = CH_ONE << last_grant_q;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign ch_grant  = ch_grant_q;
   assign ch_done   = ch_done_q;
   assign ch_err    = ch_err_q;
   assign ch_rdata  = ch_rdata_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
